// File: rtl/ula_pkg.sv
// Shared opcodes, FSM states and default widths for the sequential ULA.
// Build option ULA_MUL_EN enables the iterative multiply (op 8).
package ula_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_OP_W  = 4;

    localparam int OP_NOT = 0;
    localparam int OP_AND = 1;
    localparam int OP_OR  = 2;
    localparam int OP_XOR = 3;
    localparam int OP_ADD = 4;
    localparam int OP_SUB = 5;
    localparam int OP_SHL = 6;
    localparam int OP_SHR = 7;
    localparam int OP_MUL = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ula_mul_iter.sv
// Shift-add multiplier, one partial product per cycle over WIDTH cycles.
// product/overflow present the final step combinationally while done=1.
module ula_mul_iter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic             overflow
);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nx;
    logic [WIDTH:0]     psum;
    logic [WIDTH-1:0]   mcand;
    logic [CNT_W-1:0]   cnt;

    // Multiplier sits in the low half and shifts out as the product fills in
    always_comb begin
        psum = {1'b0, acc[2*WIDTH-1:WIDTH]};
        if (acc[0]) begin
            psum = psum + {1'b0, mcand};
        end
        acc_nx   = {psum, acc[WIDTH-1:1]};
        done     = busy && (cnt == CNT_W'(WIDTH - 1));
        product  = acc_nx[WIDTH-1:0];
        overflow = |acc_nx[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            mcand <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
        end else if (start) begin
            acc   <= {{WIDTH{1'b0}}, b};
            mcand <= a;
            cnt   <= '0;
            busy  <= 1'b1;
        end else if (busy) begin
            acc <= acc_nx;
            cnt <= cnt + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ula_seq.sv
// Registered ULA with valid/ready handshakes, status flags, illegal-op flag.
// Define ULA_MUL_EN to add the iterative multiply on op 8.
module ula_seq
    import ula_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int OP_W  = DEF_OP_W
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [OP_W-1:0]  op_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             valid_out,
    input  logic             ready_in,
    output logic [WIDTH-1:0] result_out,
    output logic             zero_out,
    output logic             carry_out,
    output logic             neg_out,
    output logic             illegal_out
);

    state_t state;
    state_t nxt;

    logic             load;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   dif;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_ill;
    logic [WIDTH-1:0] d_res;
    logic             d_c;
    logic             d_ill;

`ifdef ULA_MUL_EN
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic             is_mul;
    logic             mul_start;
    logic             mul_busy;
    logic             mul_done;
    logic [WIDTH-1:0] mul_prod;
    logic             mul_ovf;

    assign is_mul = (op_in == OP_W'(OP_MUL));

    ula_mul_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mul (
        .clk      (clk_in),
        .rst      (rst_in),
        .start    (mul_start),
        .a        (a_in),
        .b        (b_in),
        .busy     (mul_busy),
        .done     (mul_done),
        .product  (mul_prod),
        .overflow (mul_ovf)
    );
`endif

    always_comb begin
        sum     = {1'b0, a_in} + {1'b0, b_in};
        dif     = {1'b0, a_in} - {1'b0, b_in};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_ill = 1'b0;
        unique case (1'b1)
            op_in == OP_W'(OP_NOT): alu_res = ~b_in;
            op_in == OP_W'(OP_AND): alu_res = a_in & b_in;
            op_in == OP_W'(OP_OR):  alu_res = a_in | b_in;
            op_in == OP_W'(OP_XOR): alu_res = a_in ^ b_in;
            op_in == OP_W'(OP_ADD): begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
            end
            op_in == OP_W'(OP_SUB): begin
                alu_res = dif[WIDTH-1:0];
                alu_c   = dif[WIDTH];
            end
            // Shift counts >= WIDTH drain every bit and give zero
            op_in == OP_W'(OP_SHL): alu_res = a_in << b_in;
            op_in == OP_W'(OP_SHR): alu_res = a_in >> b_in;
`ifdef ULA_MUL_EN
            op_in == OP_W'(OP_MUL): alu_res = '0;
`endif
            default: alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        d_res = alu_res;
        d_c   = alu_c;
        d_ill = alu_ill;
`ifdef ULA_MUL_EN
        if (state == MUL) begin
            d_res = mul_prod;
            d_c   = mul_ovf;
            d_ill = 1'b0;
        end
`endif
    end

    always_comb begin
        nxt  = state;
        load = 1'b0;
`ifdef ULA_MUL_EN
        mul_start = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (valid_in) begin
`ifdef ULA_MUL_EN
                    if (is_mul) begin
                        mul_start = 1'b1;
                        nxt       = MUL;
                    end else begin
                        load = 1'b1;
                        nxt  = DONE;
                    end
`else
                    load = 1'b1;
                    nxt  = DONE;
`endif
                end
            end
            MUL: begin
`ifdef ULA_MUL_EN
                if (mul_done) begin
                    load = 1'b1;
                    nxt  = DONE;
                end else if (!mul_busy) begin
                    nxt = IDLE;
                end
`else
                nxt = IDLE;
`endif
            end
            DONE: begin
                if (ready_in) begin
                    nxt = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    // Result and flags persist past DONE until the next load
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            result_out  <= '0;
            zero_out    <= 1'b0;
            carry_out   <= 1'b0;
            neg_out     <= 1'b0;
            illegal_out <= 1'b0;
        end else if (load) begin
            result_out  <= d_res;
            zero_out    <= (d_res == '0);
            carry_out   <= d_c;
            neg_out     <= d_res[WIDTH-1];
            illegal_out <= d_ill;
        end
    end

    assign ready_out = (state == IDLE);
    assign valid_out = (state == DONE);

endmodule

// File: tb/tb_ula_seq.sv
// Directed self-checking bench for ula_seq at WIDTH=8.
// Multiply expectations follow whether ULA_MUL_EN is defined.
module tb_ula_seq;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic       valid_in = 1'b0;
    logic       ready_out;
    logic [3:0] op_in = 4'd0;
    logic [7:0] a_in = 8'd0;
    logic [7:0] b_in = 8'd0;
    logic       valid_out;
    logic       ready_in = 1'b0;
    logic [7:0] result_out;
    logic       zero_out;
    logic       carry_out;
    logic       neg_out;
    logic       illegal_out;

    int n_assert = 0;
    int n_fail = 0;

    always #5 clk_in = ~clk_in;

    ula_seq #(
        .WIDTH (8),
        .OP_W  (4)
    ) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .valid_in    (valid_in),
        .ready_out   (ready_out),
        .op_in       (op_in),
        .a_in        (a_in),
        .b_in        (b_in),
        .valid_out   (valid_out),
        .ready_in    (ready_in),
        .result_out  (result_out),
        .zero_out    (zero_out),
        .carry_out   (carry_out),
        .neg_out     (neg_out),
        .illegal_out (illegal_out)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // flags packed as {zero, carry, neg, illegal}
    task automatic check_out(input string tag, input logic [7:0] res,
                             input logic [3:0] flg);
        check({tag, ".valid"}, valid_out, 1);
        check({tag, ".res"}, result_out, res);
        check({tag, ".flags"},
              {zero_out, carry_out, neg_out, illegal_out}, flg);
    endtask

    task automatic issue(input string tag, input logic [3:0] op,
                         input logic [7:0] a, input logic [7:0] b,
                         input int exp_lat);
        int lat;
        @(negedge clk_in);
        check({tag, ".rdy"}, ready_out, 1);
        valid_in = 1'b1;
        op_in = op;
        a_in = a;
        b_in = b;
        @(posedge clk_in);
        #1;
        valid_in = 1'b0;
        op_in = 4'($urandom_range(0, 7));
        a_in = 8'($urandom);
        b_in = 8'($urandom);
        lat = 1;
        while (!valid_out && lat < 40) begin
            @(posedge clk_in);
            #1;
            lat++;
        end
        check({tag, ".lat"}, lat, exp_lat);
    endtask

    task automatic ack(input string tag);
        @(negedge clk_in);
        ready_in = 1'b1;
        @(posedge clk_in);
        #1;
        ready_in = 1'b0;
        check({tag, ".drop"}, {valid_out, ready_out}, 2'b01);
    endtask

    initial begin
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        check("rst.rdy", ready_out, 1);
        check("rst.valid", valid_out, 0);
        check("rst.res", result_out, 8'h00);
        check("rst.flags",
              {zero_out, carry_out, neg_out, illegal_out}, 4'b0000);

        issue("add", 4'd4, 8'hFF, 8'h01, 1);
        check_out("add", 8'h00, 4'b1100);
        ack("add");

        issue("sub0", 4'd5, 8'h00, 8'h01, 1);
        check_out("sub0", 8'hFF, 4'b0110);
        ack("sub0");

        issue("sub1", 4'd5, 8'hFF, 8'hFE, 1);
        check_out("sub1", 8'h01, 4'b0000);
        ack("sub1");

        issue("shl2", 4'd6, 8'hFF, 8'h02, 1);
        check_out("shl2", 8'hFC, 4'b0010);
        ack("shl2");

        issue("shlff", 4'd6, 8'hFF, 8'hFF, 1);
        check_out("shlff", 8'h00, 4'b1000);
        ack("shlff");

        issue("shl0", 4'd6, 8'h5A, 8'h00, 1);
        check_out("shl0", 8'h5A, 4'b0000);
        ack("shl0");

        issue("shr2", 4'd7, 8'hFF, 8'h02, 1);
        check_out("shr2", 8'h3F, 4'b0000);
        ack("shr2");

        issue("shr8", 4'd7, 8'hFF, 8'h08, 1);
        check_out("shr8", 8'h00, 4'b1000);
        ack("shr8");

        issue("not", 4'd0, 8'h00, 8'h55, 1);
        check_out("not", 8'hAA, 4'b0010);
        ack("not");

        issue("xor", 4'd3, 8'hF0, 8'h3C, 1);
        check_out("xor", 8'hCC, 4'b0010);
        ack("xor");

        issue("or", 4'd2, 8'h12, 8'h21, 1);
        check_out("or", 8'h33, 4'b0000);
        ack("or");

        issue("op9", 4'd9, 8'h12, 8'h34, 1);
        check_out("op9", 8'h00, 4'b1001);
        ack("op9");

        issue("op15", 4'd15, 8'hFF, 8'hFF, 1);
        check_out("op15", 8'h00, 4'b1001);
        ack("op15");

`ifdef ULA_MUL_EN
        issue("mul1", 4'd8, 8'd15, 8'd17, 9);
        check_out("mul1", 8'hFF, 4'b0010);
        ack("mul1");

        issue("mul2", 4'd8, 8'd16, 8'd16, 9);
        check_out("mul2", 8'h00, 4'b1100);
`else
        issue("mul2", 4'd8, 8'd16, 8'd16, 1);
        check_out("mul2", 8'h00, 4'b1001);
`endif

        // consumer stalls while a new request is presented
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            valid_in = 1'b1;
            op_in = 4'd1;
            a_in = 8'hFF;
            b_in = 8'hFF;
            check("hold.rdy", ready_out, 0);
`ifdef ULA_MUL_EN
            check_out("hold", 8'h00, 4'b1100);
`else
            check_out("hold", 8'h00, 4'b1001);
`endif
        end
        @(negedge clk_in);
        valid_in = 1'b0;
        ack("hold");
        @(negedge clk_in);
        check("noqueue", valid_out, 0);
`ifdef ULA_MUL_EN
        check("keep.res", {result_out, zero_out, carry_out}, {8'h00, 2'b11});
`else
        check("keep.res", {result_out, illegal_out}, {8'h00, 1'b1});
`endif

        // reset lands mid-multiply (or mid-DONE without the multiplier)
        @(negedge clk_in);
        valid_in = 1'b1;
        op_in = 4'd8;
        a_in = 8'd7;
        b_in = 8'd9;
        @(posedge clk_in);
        #1;
        valid_in = 1'b0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        check("abort.rdy", ready_out, 1);
        check("abort.valid", valid_out, 0);
        check("abort.res", result_out, 8'h00);
        check("abort.flags",
              {zero_out, carry_out, neg_out, illegal_out}, 4'b0000);

        issue("and", 4'd1, 8'hFF, 8'hFF, 1);
        check_out("and", 8'hFF, 4'b0010);
        ack("and");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ula_seq.md
Name: ula_seq

Overview:
- Registered, parametrised successor to the combinational 8-bit ula.
- Same op encoding for ops 0-7, generalised to WIDTH bits.
- Adds valid/ready handshakes, status flags, illegal-op detection, and an iterative multi-cycle multiply.
- Sits between the control unit's execute stage and the register-file writeback; the controller stalls on ready_out/valid_out.

Parameters:
- WIDTH, 8, operand/result width in bits (must be >= 2).
- OP_W, 4, width of the opcode field.
- CNT_W, $clog2(WIDTH)+1, width of the multiply iteration counter (derived, not overridden).

Ports:
- clk_in  input  1  system clock; all state changes on the rising edge.
- rst_in  input  1  synchronous, active-high reset.
- valid_in  input  1  request valid; op_in/a_in/b_in are sampled when valid_in && ready_out.
- ready_out  output  1  block can accept a request (high only in IDLE).
- op_in  input  OP_W  opcode.
- a_in  input  WIDTH  operand A.
- b_in  input  WIDTH  operand B.
- valid_out  output  1  result and flags valid.
- ready_in  input  1  consumer accepts the result.
- result_out  output  WIDTH  registered result.
- zero_out  output  1  result_out == 0.
- carry_out  output  1  add: carry out; sub: borrow (a < b unsigned); mul: high product half nonzero; all other ops: 0.
- neg_out  output  1  result_out[WIDTH-1].
- illegal_out  output  1  captured opcode is undefined.

Behaviour:
- Reset (synchronous, active-high): state IDLE. ready_out=1; valid_out, result_out, zero_out, carry_out, neg_out and illegal_out all 0. Reset overrides every other input and aborts any in-flight operation, including a multiply mid-iteration.
- Opcodes:
  - 0: NOT b.
  - 1: a AND b.
  - 2: a OR b.
  - 3: a XOR b.
  - 4: a+b, mod 2^WIDTH.
  - 5: a-b, mod 2^WIDTH.
  - 6: a << b.
  - 7: a >> b, logical.
  - 8: a*b, low WIDTH bits.
  - 9 and above: illegal.
- Shifts: the full b value is the shift amount. b >= WIDTH yields 0; b = 0 yields a.
- Operand capture: operands are captured at the accept edge. Input changes after accept have no effect.
- States: IDLE, MUL, DONE.
  - IDLE: on accept of ops 0-7 or an illegal op, compute and register the result; go to DONE. valid_out rises one cycle after the accept edge (latency 1). On accept of op 8, load the accumulator, clear the counter and go to MUL.
  - MUL: one shift-add step per cycle for WIDTH cycles, using a 2*WIDTH-bit accumulator. After the final step go to DONE. Latency from accept to valid_out is WIDTH+1 cycles (9 for WIDTH=8). ready_out=0 and valid_out=0 throughout.
  - DONE: valid_out=1. result_out and all flags hold stable until ready_in=1. On valid_out && ready_in, go to IDLE and drop valid_out the next cycle.
- Throughput: at most one request per 2 cycles. ready_out does not combinationally depend on ready_in.
- Illegal op: result_out=0, illegal_out=1, zero_out=1, carry_out=0, neg_out=0, with the normal single-cycle latency.
- Flags: all flags are registered together with result_out and valid only while valid_out=1. They keep their values after the DONE→IDLE transition, until the next result is registered.
- valid_in while not in IDLE is ignored; no request is queued.

Optional Feature:
- Macro: ULA_MUL_EN.
- Defined: op 8 is the iterative multiply, the MUL state exists, and the ula_mul_iter sub-module is instantiated.
- Undefined: op 8 decodes as illegal (result 0, illegal_out=1, latency 1). No MUL state, accumulator or counter is synthesised.

Decomposition:
- Package ula_pkg:
  - Opcode localparams: OP_NOT=0, OP_AND=1, OP_OR=2, OP_XOR=3, OP_ADD=4, OP_SUB=5, OP_SHL=6, OP_SHR=7, OP_MUL=8.
  - State enum: IDLE, MUL, DONE.
  - Default widths.
- Sub-module ula_mul_iter: shift-add multiplier.
  - Signals: start, busy, done, WIDTH-bit product, overflow.
  - Instantiated under ULA_MUL_EN.
- The single-cycle ops stay inline in ula_seq.

Test Plan (WIDTH=8):
- Reset → ready_out=1, valid_out=0, result_out=0x00, all flags 0. Then accept op 4, a=0xFF, b=0x01 → one cycle later valid_out=1, result_out=0x00, zero=1, carry=1, neg=0.
- op 5, a=0x00, b=0x01 → result 0xFF, carry(borrow)=1, neg=1. op 5, a=0xFF, b=0xFE → result 0x01, carry=0.
- op 6, a=0xFF, b=0x02 → 0xFC. b=0xFF → 0x00, zero=1. op 7, a=0xFF, b=0x02 → 0x3F. op 0, b=0x55 → 0xAA.
- op 8, a=15, b=17 → valid_out 9 cycles after accept, result 0xFF, carry=0. a=16, b=16 → result 0x00, zero=1, carry=1. Hold ready_in=0 for 5 cycles after valid_out → result and flags stable, ready_out=0, new valid_in ignored.
- op 9 → result 0x00, illegal_out=1. op 8 with ULA_MUL_EN undefined → illegal_out=1, latency 1.
- Reset asserted on the 4th MUL cycle → next cycle ready_out=1, valid_out=0, result_out=0x00. A subsequent op 1, a=0xFF, b=0xFF → 0xFF.
